// File: rtl/fetch_buffered_if.sv
// Fetch-stage bus bundle: writeback redirect, decode handshake and
// instruction-memory request/response channel.
// master = fetch stage, slave = surrounding pipeline and memory.
interface fetch_buffered_if #(
    parameter int unsigned XLEN = 32
);
    logic            i_PCSrc_W;
    logic [XLEN-1:0] i_Result_W;
    logic            i_Stall_D;
    logic            o_imem_req;
    logic [XLEN-1:0] o_imem_addr;
    logic            i_imem_ready;
    logic            i_imem_rvalid;
    logic [XLEN-1:0] i_imem_rdata;
    logic            o_Valid_F;
    logic [XLEN-1:0] o_Instruction_F;
    logic [XLEN-1:0] o_PC_F;
    logic [XLEN-1:0] o_PCPlus8_F;

    modport master (
        input  i_PCSrc_W, i_Result_W, i_Stall_D,
        input  i_imem_ready, i_imem_rvalid, i_imem_rdata,
        output o_imem_req, o_imem_addr,
        output o_Valid_F, o_Instruction_F, o_PC_F, o_PCPlus8_F
    );

    modport slave (
        output i_PCSrc_W, i_Result_W, i_Stall_D,
        output i_imem_ready, i_imem_rvalid, i_imem_rdata,
        input  o_imem_req, o_imem_addr,
        input  o_Valid_F, o_Instruction_F, o_PC_F, o_PCPlus8_F
    );
endinterface

// File: rtl/fetch_buffered.sv
// Instruction fetch with a DEPTH-entry prefetch queue in front of decode.
// Requests issue in order; responses land in the queue tagged with their PC.
// A redirect empties the queue and squashes every response still in flight.
// Optional FETCH_PERF_EN adds saturating delivered/redirect counters.
module fetch_buffered #(
    parameter int unsigned     XLEN     = 32,
    parameter int unsigned     DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int unsigned     PC_STEP  = 4
) (
    input  logic               i_clk,
    input  logic               i_reset,
    fetch_buffered_if.master   bus
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]        o_FetchCount,
    output logic [15:0]        o_FlushCount
`endif
);
    localparam int unsigned AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNTW = AW + 1;
    localparam int unsigned OW   = AW + 2;

    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] resp_pc_q, resp_pc_d;
    logic [XLEN-1:0] instr_mem_q [DEPTH];
    logic [XLEN-1:0] pc_mem_q    [DEPTH];
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CNTW-1:0] count_q, count_d;
    logic [OW-1:0]   out_q, out_d;
    logic [OW-1:0]   sq_q, sq_d;
    logic [OW-1:0]   live_c, occ_c;
    logic [XLEN-1:0] head_pc_c;
    logic            req_c, accept_c, drop_c, push_c, pop_c, valid_c;

    // Issue only when every live response is guaranteed a queue slot
    assign live_c   = out_q - sq_q;
    assign occ_c    = OW'(count_q) + live_c;
    assign req_c    = !i_reset && !bus.i_PCSrc_W && (occ_c < OW'(DEPTH));
    assign accept_c = req_c && bus.i_imem_ready;
    assign drop_c   = (sq_q != '0);
    assign push_c   = bus.i_imem_rvalid && !drop_c && !bus.i_PCSrc_W && !i_reset;
    assign valid_c  = (count_q != '0) && !bus.i_PCSrc_W;
    assign pop_c    = valid_c && !bus.i_Stall_D;
    assign head_pc_c = pc_mem_q[rd_ptr_q];

    assign bus.o_imem_req      = req_c;
    assign bus.o_imem_addr     = pc_q;
    assign bus.o_Valid_F       = valid_c;
    assign bus.o_Instruction_F = instr_mem_q[rd_ptr_q];
    assign bus.o_PC_F          = head_pc_c;
    assign bus.o_PCPlus8_F     = head_pc_c + XLEN'(8);

    // Next-state: net deltas for accept/response/dequeue, redirect overrides
    always_comb begin
        pc_d      = pc_q;
        resp_pc_d = resp_pc_q;
        rd_ptr_d  = rd_ptr_q;
        wr_ptr_d  = wr_ptr_q;
        count_d   = count_q;
        sq_d      = sq_q;
        out_d     = out_q + OW'(accept_c) - OW'(bus.i_imem_rvalid);
        if (bus.i_PCSrc_W) begin
            pc_d      = bus.i_Result_W;
            resp_pc_d = bus.i_Result_W;
            rd_ptr_d  = '0;
            wr_ptr_d  = '0;
            count_d   = '0;
            sq_d      = out_d;
        end else begin
            if (accept_c) begin
                pc_d = pc_q + XLEN'(PC_STEP);
            end
            if (bus.i_imem_rvalid && drop_c) begin
                sq_d = sq_q - OW'(1);
            end
            // Live responses come back in order, so their PC is implied
            if (push_c) begin
                wr_ptr_d  = wr_ptr_q + AW'(1);
                resp_pc_d = resp_pc_q + XLEN'(PC_STEP);
            end
            if (pop_c) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            count_d = count_q + CNTW'(push_c) - CNTW'(pop_c);
        end
    end

    // Control state register
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            pc_q      <= RESET_PC;
            resp_pc_q <= RESET_PC;
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            count_q   <= '0;
            out_q     <= '0;
            sq_q      <= '0;
        end else begin
            pc_q      <= pc_d;
            resp_pc_q <= resp_pc_d;
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            count_q   <= count_d;
            out_q     <= out_d;
            sq_q      <= sq_d;
        end
    end

    // Queue storage: instruction and its PC written at the tail
    always_ff @(posedge i_clk) begin
        if (push_c) begin
            instr_mem_q[wr_ptr_q] <= bus.i_imem_rdata;
            pc_mem_q[wr_ptr_q]    <= resp_pc_q;
        end
    end

`ifdef FETCH_PERF_EN
    logic [31:0] fetch_cnt_q;
    logic [15:0] flush_cnt_q;

    // Saturating counts of instructions handed to decode and redirects taken
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            fetch_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (pop_c && (fetch_cnt_q != '1)) begin
                fetch_cnt_q <= fetch_cnt_q + 32'(1);
            end
            if (bus.i_PCSrc_W && (flush_cnt_q != '1)) begin
                flush_cnt_q <= flush_cnt_q + 16'(1);
            end
        end
    end

    assign o_FetchCount = fetch_cnt_q;
    assign o_FlushCount = flush_cnt_q;
`endif
endmodule

// File: doc/fetch_buffered.md
# fetch_buffered

Parametrised instruction-fetch stage with a decoupled prefetch queue. It replaces the single-register fetch stage: it issues in-order requests to a variable-latency instruction memory, buffers returned instructions with their PCs in a DEPTH-entry queue, and presents them to decode with a valid/stall handshake. A redirect from writeback (branch or PC write) flushes the queue and squashes in-flight responses.

## Interface
- XLEN, 32, address and instruction width
- DEPTH, 4, queue entries; power of two, >= 2
- RESET_PC, 0, PC after reset
- PC_STEP, 4, PC increment per fetched instruction

- i_clk  in  1  clock; all state updates on rising edge
- i_reset  in  1  synchronous, active-high reset
- i_PCSrc_W  in  1  redirect request from writeback
- i_Result_W  in  XLEN  redirect target
- i_Stall_D  in  1  decode cannot accept this cycle
- o_imem_req  out  1  fetch request valid
- o_imem_addr  out  XLEN  fetch address (current fetch PC)
- i_imem_ready  in  1  memory accepts request this cycle
- i_imem_rvalid  in  1  response valid; responses return in request order, latency >= 1
- i_imem_rdata  in  XLEN  response instruction
- o_Valid_F  out  1  queue head valid for decode
- o_Instruction_F  out  XLEN  head instruction
- o_PC_F  out  XLEN  head PC
- o_PCPlus8_F  out  XLEN  o_PC_F + 8, modulo 2^XLEN

## Operation
- State: fetch PC, queue (instr + PC per entry, rd/wr pointers, count), outstanding counter O, squash counter S; O and S are clog2(DEPTH)+2 bits.
- Live in-flight L = O - S. Issue: o_imem_req = !i_reset && !i_PCSrc_W && (count + L < DEPTH). Guarantees every live response has a queue slot; no overflow possible.
- Request accepted (o_imem_req && i_imem_ready): O += 1, fetch PC += PC_STEP (wraps modulo 2^XLEN); PC of accepted request is tagged into a request-PC FIFO (DEPTH entries) or recomputed from queue tail.
- Response (i_imem_rvalid): O -= 1; if S > 0, S -= 1 and data dropped; else instruction + its PC written to queue tail.
- Dequeue: when o_Valid_F && !i_Stall_D, head popped.
- o_Valid_F = (count != 0) && !i_PCSrc_W; head fields combinational from queue.
- Redirect (i_PCSrc_W): at edge, queue emptied, fetch PC = i_Result_W, S_next = O_next (all in-flight, including one accepted/returned same cycle, accounted correctly). No request issued and no dequeue in the redirect cycle.
- Simultaneous accept + response + dequeue in one cycle: all three take effect; count and O updated by net deltas.
- Reset: fetch PC = RESET_PC, queue empty, O = S = 0; responses arriving after reset are the bench's responsibility (memory reset alongside).

## Timing
- Reset values: o_imem_req 0 during reset cycle; o_Valid_F 0; o_imem_addr RESET_PC in first cycle after reset.
- Best-case latency: request accepted cycle N, rvalid N+1, o_Valid_F N+2.
- Steady state with 1-cycle memory and no stall: one instruction per cycle.
- Redirect at cycle N: o_imem_req high with o_imem_addr = target at N+1 (if space); first target instruction at decode no earlier than N+3.
- Stall holds head stable; issue continues until count + L = DEPTH.

## Configuration
- FETCH_PERF_EN defined: adds ports o_FetchCount (out, 32, instructions dequeued to decode) and o_FlushCount (out, 16, redirects taken); both saturate at max, reset to 0 by i_reset.
- Undefined: ports and counters absent; behaviour otherwise identical.

## Test plan
- Reset with RESET_PC=0x100, 1-cycle memory returning addr as data -> o_PC_F sequence 0x100, 0x104, 0x108 one per cycle from cycle 3; o_PCPlus8_F = 0x108, 0x10C, ...
- i_Stall_D held high 10 cycles, DEPTH=4 -> exactly 4 requests accepted, o_imem_req low thereafter, head stays 0x100; release -> 4 instructions dequeued in order, no loss/duplication.
- 3-cycle memory latency, redirect to 0x2000 with 3 requests in flight -> those 3 responses dropped (S 3->0), next o_PC_F = 0x2000.
- Redirect in same cycle as rvalid and i_imem_ready -> response dropped, request not issued, first delivered PC = target.
- i_imem_ready toggled randomly, random stalls, 1000 instructions -> delivered PCs strictly sequential by PC_STEP, queue never exceeds DEPTH.
- FETCH_PERF_EN defined, 20 delivered instructions and 2 redirects -> o_FetchCount = 20, o_FlushCount = 2.
